// File: rtl/f3m_mult_serial.sv
// rtl/f3m_mult_serial.sv - digit-serial GF(3^97) multiplier mod x^97+x^12+2 (option macro: F3M_MULT_D2_EN)
module f3m_mult_serial #(
    parameter int M     = 97,
    parameter int WIDTH = 2*M-1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] c,
    output logic           busy,
    output logic           done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Middle term of the reduction polynomial: x^97 == 2*x^12 + 1.
    localparam int TAP = 12;

`ifdef F3M_MULT_D2_EN
    localparam int DPC = 2;
`else
    localparam int DPC = 1;
`endif

    // Iteration count; the multiplier is zero-padded at the top to a whole
    // number of digit groups so the first group of the D2 build starts at
    // a phantom coefficient 97.
    localparam int NSTEP = (M + DPC - 1) / DPC;
    localparam int BW    = 2 * DPC * NSTEP;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

    logic [1:0]     state_q, state_d;
    logic [WIDTH:0] areg_q, areg_d;
    logic [BW-1:0]  breg_q, breg_d;
    logic [WIDTH:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0] acc_step;

    // GF(3) addition; code 11 reads as 0.
    function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, (x == 2'b11) ? 2'b00 : x} + {1'b0, (y == 2'b11) ? 2'b00 : y};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // GF(3) multiplication; code 11 reads as 0.
    function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] r;
        if (x == 2'b00 || x == 2'b11 || y == 2'b00 || y == 2'b11) begin
            r = 2'b00;
        end else if (x == y) begin
            r = 2'b01;
        end else begin
            r = 2'b10;
        end
        return r;
    endfunction

    // Coefficient-wise sum of two elements.
    function automatic logic [WIDTH:0] elem_add(input logic [WIDTH:0] u, input logic [WIDTH:0] v);
        logic [WIDTH:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            r[2*i +: 2] = gf3_add(u[2*i +: 2], v[2*i +: 2]);
        end
        return r;
    endfunction

    // Whole element scaled by one GF(3) digit.
    function automatic logic [WIDTH:0] elem_scale(input logic [WIDTH:0] u, input logic [1:0] d);
        logic [WIDTH:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            r[2*i +: 2] = gf3_mul(u[2*i +: 2], d);
        end
        return r;
    endfunction

    // u*x mod P: the top coefficient wraps to degree 0 and adds 2t at the tap.
    function automatic logic [WIDTH:0] elem_shift(input logic [WIDTH:0] u);
        logic [WIDTH:0] r;
        logic [1:0]     t;
        t = u[2*(M-1) +: 2];
        r = '0;
        r[1:0] = gf3_add(t, 2'b00);
        for (int i = 1; i < M; i++) begin
            r[2*i +: 2] = u[2*(i-1) +: 2];
        end
        r[2*TAP +: 2] = gf3_add(u[2*(TAP-1) +: 2], gf3_mul(2'b10, t));
        return r;
    endfunction

    // One RUN step: Horner update with the DPC most significant pending digits.
    always_comb begin
        acc_step = acc_q;
        for (int k = 0; k < DPC; k++) begin
            acc_step = elem_add(elem_shift(acc_step),
                                elem_scale(areg_q, breg_q[BW-1-2*k -: 2]));
        end
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    areg_d  = a;
                    breg_d  = BW'(b);
                    acc_d   = '0;
                    cnt_d   = CNT_LAST;
                end
            end
            ST_RUN: begin
                acc_d  = acc_step;
                breg_d = breg_q << (2*DPC);
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign c    = acc_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule
